gemm_store_controller: RTL

- Sequences the drain of a computed output tile from the accumulator array to memory through the shared GEMM memory interface.
- Started by the load/execute controller's can_store. Drives that controller's *_store interface/address-generator inputs and returns done_store.
- Generates one write per output row: row address = tile_C_addr + r*tile_C_stride, write length = nsize.

---
 rtl/gemm_store_controller.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/gemm_store_controller.sv
// Drains an output tile from the accumulator array to memory, one row write per
// accepted request. Optional counters: define GEMM_STORE_PERF_CNT_EN.
module gemm_store_controller #(
  parameter int ADDR_W = 32,
  parameter int SIZE_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              can_store,
  input  logic [ADDR_W-1:0] tile_C_addr,
  input  logic [ADDR_W-1:0] tile_C_stride,
  input  logic [SIZE_W-1:0] msize,
  input  logic [SIZE_W-1:0] nsize,
  input  logic              mem_ready,
  output logic              gen_addr_store,
  output logic [ADDR_W-1:0] next_row_addr_store,
  output logic              interface_en_store,
  output logic              interface_rdwr_store,
  output logic [SIZE_W-1:0] interface_control_store,
  output logic              accum_rd_en,
  output logic [SIZE_W-1:0] accum_row_idx,
  output logic              done_store,
`ifdef GEMM_STORE_PERF_CNT_EN
  output logic [31:0]       perf_rows_stored,
  output logic [31:0]       perf_stall_cycles,
`endif
  output logic              busy
);

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  state_t            r_state;
  logic [SIZE_W-1:0] r_row;
  logic [SIZE_W-1:0] r_msize;
  logic [SIZE_W-1:0] r_nsize;
  logic [ADDR_W-1:0] r_row_addr;
  logic [ADDR_W-1:0] r_stride;
  logic              r_can_q;

  logic              w_start;
  logic              w_write;
  logic              w_last;
  logic [ADDR_W-1:0] w_next_addr;

  assign w_start     = can_store & ~r_can_q;
  assign w_write     = (r_state == S_WRITE);
  assign w_last      = (r_row == (r_msize - SIZE_W'(1)));
  assign w_next_addr = r_row_addr + r_stride;

  // Decode outputs from state; everything is held at zero while in reset.
  always_comb begin
    gen_addr_store          = 1'b0;
    next_row_addr_store     = '0;
    interface_en_store      = 1'b0;
    interface_rdwr_store    = 1'b0;
    interface_control_store = '0;
    accum_rd_en             = 1'b0;
    accum_row_idx           = '0;
    done_store              = 1'b0;
    busy                    = 1'b0;
    if (!rst) begin
      if (w_write) begin
        interface_en_store      = 1'b1;
        interface_rdwr_store    = 1'b1;
        interface_control_store = r_nsize;
        accum_rd_en             = 1'b1;
        accum_row_idx           = r_row;
        busy                    = 1'b1;
        if (mem_ready) begin
          if (w_last) begin
            done_store = 1'b1;
          end else begin
            gen_addr_store      = 1'b1;
            next_row_addr_store = w_next_addr;
          end
        end
      end else if (w_start) begin
        if (msize != '0) begin
          gen_addr_store      = 1'b1;
          next_row_addr_store = tile_C_addr;
        end else begin
          done_store = 1'b1;
        end
      end
    end
  end

  // Row sequencing FSM; config is latched on the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_msize    <= '0;
      r_nsize    <= '0;
      r_row_addr <= '0;
      r_stride   <= '0;
      r_can_q    <= 1'b0;
    end else begin
      r_can_q <= can_store;
      unique case (r_state)
        S_IDLE: begin
          if (w_start && (msize != '0)) begin
            r_msize    <= msize;
            r_nsize    <= nsize;
            r_stride   <= tile_C_stride;
            r_row_addr <= tile_C_addr;
            r_row      <= '0;
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_ready) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_row      <= r_row + SIZE_W'(1);
              r_row_addr <= w_next_addr;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef GEMM_STORE_PERF_CNT_EN
  // Saturating counters of accepted rows and stalled write cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rows_stored  <= '0;
      perf_stall_cycles <= '0;
    end else if (w_write) begin
      if (mem_ready) begin
        if (perf_rows_stored != '1)
          perf_rows_stored <= perf_rows_stored + 32'd1;
      end else begin
        if (perf_stall_cycles != '1)
          perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
